// File: rtl/acia_rx_fifo_if.sv
// CPU-side register port of the ACIA receive FIFO: pop/clear strobes in,
// head byte, occupancy, sticky error flags and interrupt request out.
interface acia_rx_fifo_if #(
   parameter int c_fifo_abits = 4
);
   logic                  rd;
   logic                  clr_err;
   logic                  irq_en;
   logic [7:0]            rd_data;
   logic                  rx_avail;
   logic                  rx_full;
   logic [c_fifo_abits:0] count;
   logic                  overrun;
   logic                  framing_err;
   logic                  irq_n;

   modport master (
      output rd, clr_err, irq_en,
      input  rd_data, rx_avail, rx_full, count, overrun, framing_err, irq_n
   );

   modport slave (
      input  rd, clr_err, irq_en,
      output rd_data, rx_avail, rx_full, count, overrun, framing_err, irq_n
   );
endinterface

// File: rtl/acia_rx_fifo.sv
// 8N1 serial receiver with 16x oversampling feeding a first-word-fall-through
// FIFO, sticky overrun/framing flags and a registered active-low interrupt.
module acia_rx_fifo #(
   parameter int c_clk_hz     = 25000000,
   parameter int c_baud       = 9600,
   parameter int c_fifo_abits = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rxd,
   acia_rx_fifo_if.slave bus
);

   localparam int c_div    = (c_clk_hz + 8 * c_baud) / (16 * c_baud);
   localparam int c_div_w  = (c_div > 1) ? $clog2(c_div) : 1;
   localparam int c_depth  = 2 ** c_fifo_abits;
   localparam int c_cnt_w  = c_fifo_abits + 1;
   localparam logic [c_div_w-1:0]      c_div_last  = c_div_w'(c_div - 1);
   localparam logic [c_cnt_w-1:0]      c_depth_cnt = c_cnt_w'(c_depth);
   localparam logic [c_fifo_abits-1:0] c_ptr_one   = c_fifo_abits'(1);

   typedef enum logic [2:0] {
      st_idle  = 3'd0,
      st_start = 3'd1,
      st_data  = 3'd2,
      st_stop  = 3'd3,
      st_brk   = 3'd4
   } rx_state_t;

   logic                    rx_meta_r;
   logic                    rxs_r;
   rx_state_t               state_r;
   rx_state_t               state_s;
   logic [c_div_w-1:0]      div_r;
   logic [c_div_w-1:0]      div_s;
   logic                    tick_s;
   logic [3:0]              sc_r;
   logic [3:0]              sc_s;
   logic [2:0]              bit_r;
   logic [2:0]              bit_s;
   logic [7:0]              shift_r;
   logic [7:0]              shift_s;
   logic                    push_s;
   logic                    push_r;
   logic [7:0]              push_byte_r;
   logic                    fe_set_s;

   logic [7:0]              mem_r [c_depth];
   logic [c_fifo_abits-1:0] rd_ptr_r;
   logic [c_fifo_abits-1:0] rd_ptr_s;
   logic [c_fifo_abits-1:0] wr_ptr_r;
   logic [c_fifo_abits-1:0] wr_ptr_s;
   logic [c_cnt_w-1:0]      count_r;
   logic [c_cnt_w-1:0]      count_s;
   logic                    pop_s;
   logic                    wr_en_s;
   logic                    ovr_set_s;
   logic [7:0]              head_s;
   logic [7:0]              rd_data_r;
   logic                    rx_avail_r;
   logic                    rx_full_r;
   logic                    overrun_r;
   logic                    overrun_s;
   logic                    framing_r;
   logic                    framing_s;
   logic                    irq_n_r;

   assign tick_s = (div_r == c_div_last);

   // Receive FSM next state; the divisor restarts on a start edge so ticks align to it
   always_comb begin
      state_s  = state_r;
      bit_s    = bit_r;
      shift_s  = shift_r;
      push_s   = 1'b0;
      fe_set_s = 1'b0;
      if (tick_s) begin
         div_s = '0;
         sc_s  = sc_r + 4'd1;
      end else begin
         div_s = div_r + c_div_w'(1);
         sc_s  = sc_r;
      end
      case (state_r)
         st_idle: begin
            if (!rxs_r) begin
               state_s = st_start;
               sc_s    = 4'd0;
               div_s   = '0;
            end else begin
               state_s = st_idle;
            end
         end
         st_start: begin
            if (tick_s && (sc_r == 4'd7)) begin
               if (rxs_r) begin
                  state_s = st_idle;
               end else begin
                  state_s = st_data;
                  sc_s    = 4'd0;
                  bit_s   = 3'd0;
               end
            end else begin
               state_s = st_start;
            end
         end
         st_data: begin
            if (tick_s && (sc_r == 4'd15)) begin
               shift_s = {rxs_r, shift_r[7:1]};
               bit_s   = bit_r + 3'd1;
               if (bit_r == 3'd7) begin
                  state_s = st_stop;
               end else begin
                  state_s = st_data;
               end
            end else begin
               state_s = st_data;
            end
         end
         st_stop: begin
            if (tick_s && (sc_r == 4'd15)) begin
               if (rxs_r) begin
                  push_s  = 1'b1;
                  state_s = st_idle;
               end else begin
                  fe_set_s = 1'b1;
                  state_s  = st_brk;
               end
            end else begin
               state_s = st_stop;
            end
         end
         st_brk: begin
            if (rxs_r) begin
               state_s = st_idle;
            end else begin
               state_s = st_brk;
            end
         end
         default: begin
            state_s = st_idle;
         end
      endcase
   end

   // Synchroniser, receive FSM state and the push hand-off register
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_r   <= 1'b1;
         rxs_r       <= 1'b1;
         state_r     <= st_idle;
         div_r       <= '0;
         sc_r        <= 4'd0;
         bit_r       <= 3'd0;
         shift_r     <= 8'h00;
         push_r      <= 1'b0;
         push_byte_r <= 8'h00;
      end else begin
         rx_meta_r   <= rxd;
         rxs_r       <= rx_meta_r;
         state_r     <= state_s;
         div_r       <= div_s;
         sc_r        <= sc_s;
         bit_r       <= bit_s;
         shift_r     <= shift_s;
         push_r      <= push_s;
         push_byte_r <= push_s ? shift_r : push_byte_r;
      end
   end

   // FIFO bookkeeping; head lookahead keeps rd_data valid the cycle after any change
   always_comb begin
      pop_s     = bus.rd && (count_r != '0);
      wr_en_s   = push_r && ((count_r != c_depth_cnt) || pop_s);
      ovr_set_s = push_r && (count_r == c_depth_cnt) && !pop_s;
      count_s   = count_r + c_cnt_w'(wr_en_s) - c_cnt_w'(pop_s);
      if (pop_s) begin
         rd_ptr_s = rd_ptr_r + c_ptr_one;
      end else begin
         rd_ptr_s = rd_ptr_r;
      end
      if (wr_en_s) begin
         wr_ptr_s = wr_ptr_r + c_ptr_one;
      end else begin
         wr_ptr_s = wr_ptr_r;
      end
      if (count_s == '0) begin
         head_s = 8'h00;
      end else if (wr_en_s && (wr_ptr_r == rd_ptr_s)) begin
         head_s = push_byte_r;
      end else begin
         head_s = mem_r[rd_ptr_s];
      end
      overrun_s = ovr_set_s || (overrun_r && !bus.clr_err);
      framing_s = fe_set_s  || (framing_r && !bus.clr_err);
   end

   // FIFO storage; contents need no reset since the pointers gate every read
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= push_byte_r;
      end
   end

   // FIFO pointers, registered status outputs and interrupt request
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_r   <= '0;
         wr_ptr_r   <= '0;
         count_r    <= '0;
         rd_data_r  <= 8'h00;
         rx_avail_r <= 1'b0;
         rx_full_r  <= 1'b0;
         overrun_r  <= 1'b0;
         framing_r  <= 1'b0;
         irq_n_r    <= 1'b1;
      end else begin
         rd_ptr_r   <= rd_ptr_s;
         wr_ptr_r   <= wr_ptr_s;
         count_r    <= count_s;
         rd_data_r  <= head_s;
         rx_avail_r <= (count_s != '0);
         rx_full_r  <= (count_s == c_depth_cnt);
         overrun_r  <= overrun_s;
         framing_r  <= framing_s;
         irq_n_r    <= !(bus.irq_en && (count_s != '0));
      end
   end

   assign bus.rd_data     = rd_data_r;
   assign bus.rx_avail    = rx_avail_r;
   assign bus.rx_full     = rx_full_r;
   assign bus.count       = count_r;
   assign bus.overrun     = overrun_r;
   assign bus.framing_err = framing_r;
   assign bus.irq_n       = irq_n_r;

endmodule

// File: tb/tb_acia_rx_fifo.sv
// Directed bench for acia_rx_fifo, run at a reduced clock so one bit is
// 16*5 = 80 clk (the divisor formula rounds 4.75 up to 5 at this clock).
module tb_acia_rx_fifo;

   localparam int c_clk_hz   = 729600;
   localparam int c_baud     = 9600;
   localparam int c_abits    = 4;
   localparam int c_div      = 5;
   localparam int c_bit      = 16 * c_div;
   localparam int c_frame    = 10 * c_bit;
   // cycles from driving the start edge to the edge that samples the stop bit
   localparam int c_stop_cyc = 3 + 152 * c_div;

   logic clk = 1'b0;
   logic reset;
   logic rxd;
   int   n_vec  = 0;
   int   n_fail = 0;
   logic mon_en = 1'b0;
   int   min_cnt = 99;

   acia_rx_fifo_if #(.c_fifo_abits(c_abits)) bus ();

   acia_rx_fifo #(
      .c_clk_hz    (c_clk_hz),
      .c_baud      (c_baud),
      .c_fifo_abits(c_abits)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .rxd  (rxd),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mon_en && (int'(bus.count) < min_cnt)) min_cnt <= int'(bus.count);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rd_cyc, input int n_cyc);
      int bi;
      for (int c = 0; c < n_cyc; c++) begin
         @(posedge clk);
         #1;
         bi = c / c_bit;
         if (bi == 0) rxd = 1'b0;
         else if (bi <= 8) rxd = b[bi-1];
         else rxd = stop_bit;
         bus.rd = (c == rd_cyc);
      end
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 1'b1, -1, c_frame);
   endtask

   task automatic pop();
      @(posedge clk);
      #1 bus.rd = 1'b1;
      @(posedge clk);
      #1 bus.rd = 1'b0;
   endtask

   task automatic pulse_clr();
      @(posedge clk);
      #1 bus.clr_err = 1'b1;
      @(posedge clk);
      #1 bus.clr_err = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      rxd         = 1'b1;
      bus.rd      = 1'b0;
      bus.clr_err = 1'b0;
      bus.irq_en  = 1'b0;
      step(3);
      check("rst_count",   32'(bus.count),       32'd0);
      check("rst_avail",   32'(bus.rx_avail),    32'd0);
      check("rst_full",    32'(bus.rx_full),     32'd0);
      check("rst_data",    32'(bus.rd_data),     32'h00);
      check("rst_ovr",     32'(bus.overrun),     32'd0);
      check("rst_fe",      32'(bus.framing_err), 32'd0);
      check("rst_irq",     32'(bus.irq_n),       32'd1);
      reset      = 1'b0;
      bus.irq_en = 1'b1;
      step(2 * c_bit);

      // single byte, interrupt and pop
      send(8'h55);
      step(c_bit);
      check("t1_avail", 32'(bus.rx_avail), 32'd1);
      check("t1_data",  32'(bus.rd_data),  32'h55);
      check("t1_count", 32'(bus.count),    32'd1);
      check("t1_irq",   32'(bus.irq_n),    32'd0);
      bus.irq_en = 1'b0;
      step(2);
      check("t1_irq_masked", 32'(bus.irq_n), 32'd1);
      bus.irq_en = 1'b1;
      step(2);
      check("t1_irq_unmask", 32'(bus.irq_n), 32'd0);
      pop();
      step(1);
      check("t1_pop_count", 32'(bus.count),   32'd0);
      check("t1_pop_irq",   32'(bus.irq_n),   32'd1);
      check("t1_pop_data",  32'(bus.rd_data), 32'h00);
      pop();
      step(1);
      check("t1_empty_rd_count", 32'(bus.count), 32'd0);

      // 17 bytes into a 16-deep FIFO
      for (int i = 0; i < 17; i++) send(8'(i));
      step(c_bit);
      check("t2_count", 32'(bus.count),    32'd16);
      check("t2_full",  32'(bus.rx_full),  32'd1);
      check("t2_ovr",   32'(bus.overrun),  32'd1);
      check("t2_avail", 32'(bus.rx_avail), 32'd1);
      for (int i = 0; i < 16; i++) begin
         check("t2_read", 32'(bus.rd_data), 32'(i));
         pop();
      end
      step(1);
      check("t2_drained", 32'(bus.count),   32'd0);
      check("t2_nfull",   32'(bus.rx_full), 32'd0);
      pulse_clr();
      step(1);
      check("t2_ovr_clr", 32'(bus.overrun), 32'd0);

      // framing error, then line held low
      send_frame(8'hA5, 1'b0, -1, c_frame);
      step(c_frame);
      check("t3_fe",    32'(bus.framing_err), 32'd1);
      check("t3_count", 32'(bus.count),       32'd0);
      rxd = 1'b1;
      step(3 * c_bit);
      check("t3_brk_count", 32'(bus.count),       32'd0);
      check("t3_fe_sticky", 32'(bus.framing_err), 32'd1);
      pulse_clr();
      step(1);
      check("t3_fe_clr", 32'(bus.framing_err), 32'd0);

      // short low glitch is a false start; the next frame still arrives
      rxd = 1'b0;
      step(30);
      rxd = 1'b1;
      step(3 * c_bit);
      check("t4_count", 32'(bus.count),       32'd0);
      check("t4_fe",    32'(bus.framing_err), 32'd0);
      send(8'h5A);
      step(c_bit);
      check("t4_after_count", 32'(bus.count),   32'd1);
      check("t4_after_data",  32'(bus.rd_data), 32'h5A);
      pop();

      // reset in the middle of a byte
      send_frame(8'hEE, 1'b0, -1, c_frame);
      rxd = 1'b1;
      step(2 * c_bit);
      send(8'h11);
      send_frame(8'hC3, 1'b1, -1, 5 * c_bit);
      check("t5_pre_count", 32'(bus.count),       32'd1);
      check("t5_pre_fe",    32'(bus.framing_err), 32'd1);
      reset = 1'b1;
      rxd   = 1'b1;
      step(2);
      check("t5_count", 32'(bus.count),       32'd0);
      check("t5_avail", 32'(bus.rx_avail),    32'd0);
      check("t5_data",  32'(bus.rd_data),     32'h00);
      check("t5_fe",    32'(bus.framing_err), 32'd0);
      check("t5_irq",   32'(bus.irq_n),       32'd1);
      reset = 1'b0;
      step(2 * c_bit);
      send(8'h3C);
      step(c_bit);
      check("t5_next_count", 32'(bus.count),   32'd1);
      check("t5_next_data",  32'(bus.rd_data), 32'h3C);
      check("t5_next_irq",   32'(bus.irq_n),   32'd0);
      pop();

      // full FIFO: pop coincident with the stop-bit push
      for (int i = 0; i < 16; i++) send(8'h20 + 8'(i));
      step(c_bit);
      check("t6_fill_count", 32'(bus.count),   32'd16);
      check("t6_fill_ovr",   32'(bus.overrun), 32'd0);
      min_cnt = 99;
      mon_en  = 1'b1;
      send_frame(8'h7E, 1'b1, c_stop_cyc, c_frame);
      step(4);
      mon_en = 1'b0;
      step(1);
      check("t6_min_count", 32'(min_cnt),      32'd16);
      check("t6_count",     32'(bus.count),    32'd16);
      check("t6_ovr",       32'(bus.overrun),  32'd0);
      check("t6_full",      32'(bus.rx_full),  32'd1);
      for (int i = 0; i < 16; i++) begin
         check("t6_read", 32'(bus.rd_data), (i < 15) ? 32'(8'h21 + 8'(i)) : 32'h7E);
         pop();
      end
      step(1);
      check("t6_drained", 32'(bus.count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
